// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Used by the RTL and visible to any block that issues operations.
package mult_div_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main control unit and the
// multiply/divide sequencer.
interface mult_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring on
// magnitudes) sequencer with HI/LO result registers.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  state_e             state;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               q_1;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;
  logic               neg_r;
  logic               div0_flag;

  logic               busy_r;
  logic               done_r;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept;
  logic               last_iter;
  logic               load_res;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               done_next;
  logic               div0_next;

  logic [WIDTH:0]     opnd_x;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     booth_hi;
  logic [WIDTH-1:0]   booth_lo;
  logic               booth_q;

  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_quo;

  logic [WIDTH-1:0]   fix_quo;
  logic [WIDTH-1:0]   fix_rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ((~x) + WIDTH'(1)) : x;
  endfunction

  // A start arriving in the done cycle is dropped, not queued.
  assign accept    = (state == IDLE) && bus.start && !done_r;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Booth step: WIDTH+1 bit adder keeps a = -2^(WIDTH-1) representable.
  assign opnd_x = {opnd[WIDTH-1], opnd};

  always_comb begin
    unique case ({acc_lo[0], q_1})
      2'b01:   booth_sum = acc_hi + opnd_x;
      2'b10:   booth_sum = acc_hi - opnd_x;
      default: booth_sum = acc_hi;
    endcase
  end

  assign booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
  assign booth_q  = acc_lo[0];

  // Restoring step on magnitudes: a negative trial difference restores.
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_rem   = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
  assign div_quo   = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};

  // Sign fix-up: quotient follows sign(a)^sign(b), remainder follows a.
  assign fix_quo = neg_q ? ((~acc_lo) + WIDTH'(1)) : acc_lo;
  assign fix_rem = neg_r ? ((~acc_hi[WIDTH-1:0]) + WIDTH'(1)) : acc_hi[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_res   = 1'b0;
    res_hi     = hi_r;
    res_lo     = lo_r;
    done_next  = 1'b0;
    div0_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_MULT) begin
            state_next = MULT;
          end else if (bus.b == '0) begin
            // Divide by zero skips iteration; FIX leaves hi/lo untouched.
            state_next = FIX;
          end else begin
            state_next = DIV;
          end
        end
      end
      MULT: begin
        if (last_iter) begin
          state_next = DONE;
          load_res   = 1'b1;
          res_hi     = booth_hi[WIDTH-1:0];
          res_lo     = booth_lo;
        end
      end
      DIV: begin
        if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
        if (!div0_flag) begin
          load_res = 1'b1;
          res_hi   = fix_rem;
          res_lo   = fix_quo;
        end
      end
      DONE: begin
        state_next = IDLE;
        done_next  = 1'b1;
        div0_next  = div0_flag;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers, iteration counter and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      q_1       <= 1'b0;
      opnd      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0_flag <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      div0_r    <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      busy_r <= (state_next != IDLE);
      done_r <= done_next;
      div0_r <= div0_next;
      if (load_res) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            q_1       <= 1'b0;
            acc_hi    <= '0;
            div0_flag <= (bus.op == OP_DIV) && (bus.b == '0);
            if (bus.op == OP_MULT) begin
              opnd   <= bus.a;
              acc_lo <= bus.b;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              opnd   <= mag(bus.b);
              acc_lo <= mag(bus.a);
              neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r  <= bus.a[WIDTH-1];
            end
          end
        end
        MULT: begin
          acc_hi <= booth_hi;
          acc_lo <= booth_lo;
          q_1    <= booth_q;
          cnt    <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc_hi <= div_rem;
          acc_lo <= div_quo;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed cases plus random
// operations against a plain-arithmetic reference model.
module tb_mult_div_ctrl;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_div_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Results the model believes are currently held in HI/LO.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic, truncating division.
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ed0, output int lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0) begin
      p = sa * sb;
      eh = p[63:32]; el = p[31:0]; ed0 = 1'b0; lat = 33;
    end else if (b == 32'd0) begin
      eh = m_hi; el = m_lo; ed0 = 1'b1; lat = 2;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0]; el = q[31:0]; ed0 = 1'b0; lat = 34;
    end
  endtask

  // Issue one operation; optionally pulse a stray start at cycle inj.
  task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input int inj);
    logic [31:0] eh, el, h0, l0;
    logic ed0, stable;
    int lat, k, busy_n;
    model(op, a, b, eh, el, ed0, lat);
    h0 = bus.hi; l0 = bus.lo;
    stable = 1'b1; busy_n = 0; k = 0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!bus.done && k < 100) begin
      if (bus.busy) busy_n++;
      if (k < lat - 1 && (bus.hi !== h0 || bus.lo !== l0)) stable = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.op = 1'($urandom_range(0, 1));
      bus.start = 1'b0;
      if (k == inj) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.b = 32'd0;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_div0"}, 64'(bus.div0), 64'(ed0));
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
    check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
    m_hi = eh; m_lo = el;
    // start during the done cycle must be dropped
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1; bus.b = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_single_done"}, 64'(bus.done), 64'd0);
    check({tag, "_start_in_done_ignored"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic op;
    logic [31:0] a, b;
    logic seen;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div0", 64'(bus.div0), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("mul_7_m3_lit_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("mul_min_min_lit_hi", 64'(bus.hi), 64'h4000_0000);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
    check("div_100_7_lit_lo", 64'(bus.lo), 64'd14);
    do_op("div_setup", 1'b1, 32'h451, 32'h20, -1);
    do_op("div_by_zero", 1'b1, 32'd5, 32'd0, -1);
    check("div_by_zero_lit_hi", 64'(bus.hi), 64'h11);
    do_op("mul_stray_start", 1'b0, 32'd5, 32'd6, 10);
    check("mul_stray_start_lit_lo", 64'(bus.lo), 64'd30);
    do_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op("div_neg_divisor", 1'b1, 32'd17, 32'hFFFF_FFFB, -1);
    do_op("mul_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);

    for (int i = 0; i < 12; i++) begin
      op = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), op, a, b, -1);
    end

    // reset in the middle of a divide aborts it and clears results
    seen = 1'b0;
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'hFFFF_0123; bus.b = 32'h0000_0345;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    do_op("mul_after_rst", 1'b0, 32'd3, 32'd4, -1);
    check("mul_after_rst_lit_lo", 64'(bus.lo), 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
